epd: RTL and testbench

- Ethernet packet detector on a byte-wide receive stream qualified by `control` (1 = in-frame byte, 0 = idle/IFG).
- Validates preamble/SFD, destination MAC, source MAC, type/length and overall frame size.
- Raises one status flag per field and counts complete valid frames.
- Sits directly after the byte deserializer in the RX datapath.

---
 rtl/epd_pkg.sv | 27 ++
 rtl/epd_field_shift.sv | 42 ++++
 rtl/epd.sv | 192 +++++++++++++++++++
 tb/tb_epd.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/epd_pkg.sv
// Shared types and protocol constants for the Ethernet packet detector (epd).
package epd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DST,
    S_SRC,
    S_TYPE,
    S_PAYLOAD,
    S_DROP
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] ETHERTYPE_MIN = 16'h0600;
  localparam logic [15:0] LEN_MIN       = 16'd46;
  localparam logic [15:0] LEN_MAX       = 16'd1500;
  localparam logic [2:0]  ADDR_BYTES    = 3'd6;
  localparam logic [2:0]  TYPE_BYTES    = 3'd2;

  // 46..1500 is an 802.3 length; 0x0600 and above is an EtherType.
  function automatic logic type_len_ok(input logic [15:0] v);
    return ((v >= LEN_MIN) && (v <= LEN_MAX)) || (v >= ETHERTYPE_MIN);
  endfunction

endpackage

// File: rtl/epd_field_shift.sv
// Header field capture: shifts DST/SRC/TYPE bytes MSB-first and flags the last byte
// of the current field, together with all-zero and 16-bit views of it.
module epd_field_shift
  import epd_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic        type_field,
  input  logic [7:0]  data,
  output logic        field_done,
  output logic        field_zero,
  output logic [15:0] field_word
);

  logic [39:0] shreg_p0;
  logic [2:0]  byte_cnt;
  logic [2:0]  field_len;

  assign field_len = type_field ? TYPE_BYTES : ADDR_BYTES;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      byte_cnt <= '0;
    else if (clear || field_done)
      byte_cnt <= '0;
    else if (shift_en)
      byte_cnt <= byte_cnt + 3'd1;
  end

  always_ff @(posedge clock) begin
    if (shift_en)
      shreg_p0 <= {shreg_p0[31:0], data};
  end

  // Results include the byte being sampled, so the FSM can act on the last edge.
  assign field_done = shift_en && (byte_cnt == (field_len - 3'd1));
  assign field_zero = ({shreg_p0, data} == 48'd0);
  assign field_word = {shreg_p0[7:0], data};

endmodule

// File: rtl/epd.sv
// Ethernet packet detector: validates preamble/SFD, DST, SRC, type/length and frame
// size on a byte stream and counts good frames. Define EPD_JUMBO_EN for 9018-byte frames.
module epd
  import epd_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 64,
  parameter int MAX_FRAME    = 1518
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       control,
  output logic       preamble_valid,
  output logic       dst_addr_valid,
  output logic       src_addr_valid,
  output logic       type_length_valid,
  output logic       packet_size_valid,
  output logic [3:0] valid_packet_counter
);

`ifdef EPD_JUMBO_EN
  localparam int CNT_W   = 14;
  localparam int MAX_LIM = 9018;
`else
  localparam int CNT_W   = 11;
  localparam int MAX_LIM = MAX_FRAME;
`endif
  localparam int PCNT_W = $clog2(PREAMBLE_LEN + 1);

  localparam logic [CNT_W-1:0]  MIN_C = CNT_W'(MIN_FRAME);
  localparam logic [CNT_W-1:0]  MAX_C = CNT_W'(MAX_LIM);
  localparam logic [PCNT_W-1:0] PRE_C = PCNT_W'(PREAMBLE_LEN);

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [PCNT_W-1:0] sat_inc_pre(input logic [PCNT_W-1:0] v);
    return (v >= PRE_C) ? PRE_C : v + 1'b1;
  endfunction

  state_t            state, state_nxt;
  logic [PCNT_W-1:0] pre_cnt;
  logic [CNT_W-1:0]  byte_cnt;
  logic              in_field, in_frame;
  logic              field_done, field_zero;
  logic [15:0]       field_word;
  logic              sfd_ok, dst_ok, src_ok, type_ok, size_ok, frame_end;
  logic              pre_inc, pre_clr;

  assign in_field = (state == S_DST) || (state == S_SRC) || (state == S_TYPE);
  assign in_frame = in_field || (state == S_PAYLOAD);

  epd_field_shift u_field (
    .clock      (clock),
    .reset      (reset),
    .clear      (!in_field || !control),
    .shift_en   (control && in_field),
    .type_field (state == S_TYPE),
    .data       (data),
    .field_done (field_done),
    .field_zero (field_zero),
    .field_word (field_word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sfd_ok    = 1'b0;
    dst_ok    = 1'b0;
    src_ok    = 1'b0;
    type_ok   = 1'b0;
    size_ok   = 1'b0;
    frame_end = 1'b0;
    pre_inc   = 1'b0;
    pre_clr   = 1'b0;
    case (state)
      S_IDLE, S_PREAMBLE: begin
        if (!control) begin
          pre_clr   = 1'b1;
          state_nxt = S_IDLE;
        end else if (data == PREAMBLE_BYTE) begin
          pre_inc   = 1'b1;
          state_nxt = S_PREAMBLE;
        end else if (data == SFD_BYTE) begin
          pre_clr = 1'b1;
          if (pre_cnt >= PRE_C) begin
            sfd_ok    = 1'b1;
            state_nxt = S_DST;
          end else begin
            state_nxt = S_DROP;
          end
        end else begin
          pre_clr   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DST: begin
        if (!control) begin
          frame_end = 1'b1;
          state_nxt = S_IDLE;
        end else if (field_done) begin
          dst_ok    = !field_zero;
          state_nxt = field_zero ? S_DROP : S_SRC;
        end
      end
      S_SRC: begin
        if (!control) begin
          frame_end = 1'b1;
          state_nxt = S_IDLE;
        end else if (field_done) begin
          src_ok    = !field_zero;
          state_nxt = field_zero ? S_DROP : S_TYPE;
        end
      end
      S_TYPE: begin
        if (!control) begin
          frame_end = 1'b1;
          state_nxt = S_IDLE;
        end else if (field_done) begin
          type_ok   = type_len_ok(field_word);
          state_nxt = type_ok ? S_PAYLOAD : S_DROP;
        end
      end
      S_PAYLOAD: begin
        if (!control) begin
          frame_end = 1'b1;
          size_ok   = (byte_cnt >= MIN_C) && (byte_cnt <= MAX_C);
          state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        if (!control) begin
          frame_end = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      if (pre_clr)
        pre_cnt <= '0;
      else if (pre_inc)
        pre_cnt <= sat_inc_pre(pre_cnt);
      if (sfd_ok)
        byte_cnt <= '0;
      else if (control && in_frame)
        byte_cnt <= sat_inc_cnt(byte_cnt);
    end
  end

  // Output stage: flags and the frame counter are registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      preamble_valid       <= 1'b0;
      dst_addr_valid       <= 1'b0;
      src_addr_valid       <= 1'b0;
      type_length_valid    <= 1'b0;
      packet_size_valid    <= 1'b0;
      valid_packet_counter <= '0;
    end else begin
      packet_size_valid <= size_ok;
      if (size_ok)
        valid_packet_counter <= valid_packet_counter + 4'd1;
      if (frame_end) begin
        preamble_valid    <= 1'b0;
        dst_addr_valid    <= 1'b0;
        src_addr_valid    <= 1'b0;
        type_length_valid <= 1'b0;
      end else begin
        if (sfd_ok)  preamble_valid    <= 1'b1;
        if (dst_ok)  dst_addr_valid    <= 1'b1;
        if (src_ok)  src_addr_valid    <= 1'b1;
        if (type_ok) type_length_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_epd.sv
// Directed testbench for epd with a scoreboard of expected counter values at each pulse.
module tb_epd;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       control = 1'b0;
  logic [7:0] data = 8'h00;
  logic       preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid;
  logic       packet_size_valid;
  logic [3:0] valid_packet_counter;

  epd dut (
    .clock                (clock),
    .reset                (reset),
    .data                 (data),
    .control              (control),
    .preamble_valid       (preamble_valid),
    .dst_addr_valid       (dst_addr_valid),
    .src_addr_valid       (src_addr_valid),
    .type_length_valid    (type_length_valid),
    .packet_size_valid    (packet_size_valid),
    .valid_packet_counter (valid_packet_counter)
  );

  always #5 clock = ~clock;

  int         tests = 0;
  int         fails = 0;
  int         pulse_cnt = 0;
  int         model_cnt = 0;
  logic [3:0] exp_q[$];

  localparam logic [47:0] DST_A = 48'h010203040506;
  localparam logic [47:0] SRC_A = 48'hFFFEFDFCFBFA;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pops the expected counter value whenever the DUT pulses packet_size_valid.
  always @(negedge clock) begin
    if (!reset && packet_size_valid === 1'b1) begin
      pulse_cnt++;
      if (exp_q.size() == 0)
        chk("unexpected_pulse", 32'd1, 32'd0);
      else
        chk("counter_at_pulse", 32'(valid_packet_counter), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic c, input logic [7:0] d);
    @(negedge clock);
    control = c;
    data    = d;
    @(posedge clock);
    #1;
  endtask

  task automatic header(input int pre_n, input bit junk, input logic [47:0] dst,
                        input logic [47:0] src, input logic [15:0] tl);
    if (junk) step(1'b1, 8'h00);
    repeat (pre_n) step(1'b1, 8'h55);
    step(1'b1, 8'hD5);
    for (int i = 0; i < 6; i++) step(1'b1, dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) step(1'b1, src[47-8*i -: 8]);
    step(1'b1, tl[15:8]);
    step(1'b1, tl[7:0]);
  endtask

  task automatic send_frame(input string tag, input int pre_n, input bit junk,
                            input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] tl, input int total, input int ifg);
    bit pre_ok, dst_ok, src_ok, tl_ok, good;
    int p0;
    pre_ok = (pre_n >= 7);
    dst_ok = pre_ok && (dst != 48'd0);
    src_ok = dst_ok && (src != 48'd0);
    tl_ok  = src_ok && (((tl >= 16'd46) && (tl <= 16'd1500)) || (tl >= 16'h0600));
    good   = tl_ok && (total >= 64) && (total <= 1518);
    p0     = pulse_cnt;
    if (junk) step(1'b1, 8'h00);
    repeat (pre_n) step(1'b1, 8'h55);
    step(1'b1, 8'hD5);
    chk({tag, "_pre"}, 32'(preamble_valid), 32'(pre_ok));
    for (int i = 0; i < 6; i++) step(1'b1, dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) step(1'b1, src[47-8*i -: 8]);
    step(1'b1, tl[15:8]);
    step(1'b1, tl[7:0]);
    chk({tag, "_dst"}, 32'(dst_addr_valid), 32'(dst_ok));
    chk({tag, "_src"}, 32'(src_addr_valid), 32'(src_ok));
    chk({tag, "_tl"}, 32'(type_length_valid), 32'(tl_ok));
    if (good) begin
      model_cnt = (model_cnt + 1) % 16;
      exp_q.push_back(model_cnt[3:0]);
    end
    for (int i = 14; i < total; i++) step(1'b1, 8'(i));
    step(1'b0, 8'hAA);
    chk({tag, "_pulse"}, 32'(packet_size_valid), 32'(good));
    chk({tag, "_flags_clr"},
        32'({preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid}), 32'd0);
    repeat (ifg) step(1'b0, 8'h55);
    chk({tag, "_npulse"}, 32'(pulse_cnt - p0), 32'(good));
    chk({tag, "_count"}, 32'(valid_packet_counter), 32'(model_cnt));
  endtask

  initial begin
    #1 reset = 1'b1;
    #20;
    chk("reset_outputs",
        32'({preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid,
             packet_size_valid, valid_packet_counter}), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    step(1'b0, 8'h00);

    send_frame("basic",     7, 1'b1, DST_A, SRC_A, 16'h0800, 64, 1);
    send_frame("trunc",     7, 1'b0, DST_A, SRC_A, 16'h0800, 43, 3);
    send_frame("after_ifg", 7, 1'b0, DST_A, SRC_A, 16'h0800, 70, 1);
    send_frame("short_pre", 6, 1'b0, DST_A, SRC_A, 16'h0800, 64, 1);
    send_frame("long_pre",  9, 1'b0, DST_A, SRC_A, 16'h0800, 64, 1);
    send_frame("dst_zero",  7, 1'b0, 48'd0, SRC_A, 16'h0800, 64, 1);
    send_frame("src_zero",  7, 1'b0, DST_A, 48'd0, 16'h0800, 64, 1);
    send_frame("len_0550",  7, 1'b0, DST_A, SRC_A, 16'h0550, 64, 1);
    send_frame("len_05FF",  7, 1'b0, DST_A, SRC_A, 16'h05FF, 64, 1);
    send_frame("len_002E",  7, 1'b0, DST_A, SRC_A, 16'h002E, 64, 1);
    send_frame("len_002D",  7, 1'b0, DST_A, SRC_A, 16'h002D, 64, 1);
    send_frame("size_63",   7, 1'b0, DST_A, SRC_A, 16'h0800, 63, 1);
    send_frame("size_1519", 7, 1'b0, DST_A, SRC_A, 16'h0800, 1519, 1);
    send_frame("size_1518", 7, 1'b0, DST_A, SRC_A, 16'h0800, 1518, 1);
    send_frame("size_64",   7, 1'b0, DST_A, SRC_A, 16'h0800, 64, 1);

    // Reset asserted mid-payload must clear everything without waiting for a clock edge.
    header(7, 1'b0, DST_A, SRC_A, 16'h0800);
    repeat (10) step(1'b1, 8'h3C);
    #2 reset = 1'b1;
    #1;
    chk("midreset_outputs",
        32'({preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid,
             packet_size_valid, valid_packet_counter}), 32'd0);
    @(negedge clock);
    reset   = 1'b0;
    control = 1'b0;
    model_cnt = 0;
    exp_q.delete();
    step(1'b0, 8'h00);
    send_frame("post_reset", 7, 1'b0, DST_A, SRC_A, 16'h86DD, 64, 1);

    for (int k = 0; k < 15; k++)
      send_frame("wrap", 7, 1'b0, DST_A, SRC_A, 16'h0800, 64, 1);
    chk("wrap_to_zero", 32'(valid_packet_counter), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
